// File: rtl/avmm_resp_pkg.sv
// Shared types and width helpers for the Avalon-MM burst responder.
package avmm_resp_pkg;

    // Responder FSM encoding.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_LAT   = 2'd1,
        S_RD_BURST = 2'd2,
        S_WR_BURST = 2'd3
    } resp_state_e;

    localparam int unsigned STATE_W        = 2;
    localparam int unsigned LAT_W          = 4;
    localparam int unsigned BEAT_W_DEFAULT = 11;

    // Beat counter type at the wrappers' 11-bit burstcount width.
    typedef logic [BEAT_W_DEFAULT-1:0] beat_idx_t;

    // Bytes carried by one data word.
    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Shift that turns a byte offset into a word index.
    function automatic int unsigned word_shift(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/avmm_resp_ram.sv
// Single-port synchronous RAM with byte-enable writes and a 1-cycle registered read.
module avmm_resp_ram
    import avmm_resp_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic                        re,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [bytes_per_word(DATA_W)-1:0] be,
    output logic [DATA_W-1:0]           q
);

    localparam int unsigned NBYTES = bytes_per_word(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read share the one port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/avmm_burst_responder.sv
// Avalon-MM burst slave backed by an on-chip byte-enable RAM; one burst at a time.
module avmm_burst_responder
    import avmm_resp_pkg::*;
#(
    parameter int unsigned SDRAM_W    = 128,
    parameter int unsigned BURST_W    = 11,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned GAP_EVERY  = 0,
    parameter string       INIT_FILE  = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            address,
    input  logic [BURST_W-1:0]     burstcount,
    input  logic                   read,
    input  logic                   write,
    input  logic [SDRAM_W-1:0]     writedata,
    input  logic [SDRAM_W/8-1:0]   byteenable,
    output logic                   waitrequest,
    output logic [SDRAM_W-1:0]     readdata,
    output logic                   readdatavalid,
    output logic                   busy,
    output logic                   err_oob,
    output logic                   err_proto
);

    localparam int unsigned SHIFT    = word_shift(SDRAM_W);
    localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned LAT_LOAD = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    localparam logic [STATE_W-1:0] ST_IDLE     = STATE_W'(S_IDLE);
    localparam logic [STATE_W-1:0] ST_RD_LAT   = STATE_W'(S_RD_LAT);
    localparam logic [STATE_W-1:0] ST_RD_BURST = STATE_W'(S_RD_BURST);
    localparam logic [STATE_W-1:0] ST_WR_BURST = STATE_W'(S_WR_BURST);

    logic [STATE_W-1:0] state_q, state_n;
    logic [BURST_W-1:0] beat_q, beat_n;
    logic [BURST_W-1:0] gap_q, gap_n;
    logic [LAT_W-1:0]   lat_q, lat_n;
    logic [31:0]        idx_q, idx_n;
    logic               below_q, below_n;
    logic               pend_q, pend_oob_q;

    logic [31:0]        acc_idx;
    logic               acc_below;
    logic               cnt_zero;
    logic [BURST_W-1:0] eff_cnt;
    logic [31:0]        cur_idx;
    logic               cur_oob;
    logic               bubble;
    logic               issue, commit, proto_set, wait_n;
    logic [SDRAM_W-1:0] ram_q;

    // Command decode: word index of the incoming address and effective burst length.
    always_comb begin
        acc_idx   = (address - BASE_ADDR) >> SHIFT;
        acc_below = (address < BASE_ADDR);
        cnt_zero  = (burstcount == '0);
        eff_cnt   = cnt_zero ? BURST_W'(1) : burstcount;
        cur_idx   = (state_q == ST_IDLE) ? acc_idx : idx_q;
        cur_oob   = ((state_q == ST_IDLE) ? acc_below : below_q) || (cur_idx >= 32'(MEM_DEPTH));
        bubble    = (GAP_EVERY != 0) && (gap_q == BURST_W'(GAP_EVERY));
    end

    // Next-state, beat issue/commit and registered-output precompute.
    always_comb begin
        state_n   = state_q;
        beat_n    = beat_q;
        gap_n     = gap_q;
        lat_n     = lat_q;
        idx_n     = idx_q;
        below_n   = below_q;
        issue     = 1'b0;
        commit    = 1'b0;
        proto_set = 1'b0;
        wait_n    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (write) begin
                    commit    = 1'b1;
                    idx_n     = acc_idx + 32'd1;
                    below_n   = acc_below;
                    gap_n     = BURST_W'(1);
                    proto_set = read || cnt_zero;
                    if (eff_cnt != BURST_W'(1)) begin
                        beat_n  = eff_cnt - BURST_W'(1);
                        state_n = ST_WR_BURST;
                    end
                end else if (read) begin
                    proto_set = cnt_zero;
                    below_n   = acc_below;
                    if (RD_LATENCY <= 1) begin
                        issue   = 1'b1;
                        idx_n   = acc_idx + 32'd1;
                        beat_n  = eff_cnt - BURST_W'(1);
                        gap_n   = BURST_W'(1);
                        state_n = ST_RD_BURST;
                    end else begin
                        idx_n   = acc_idx;
                        beat_n  = eff_cnt;
                        gap_n   = '0;
                        lat_n   = LAT_W'(LAT_LOAD);
                        state_n = ST_RD_LAT;
                    end
                end
            end
            ST_RD_LAT: begin
                if (lat_q == '0) begin
                    issue   = 1'b1;
                    idx_n   = idx_q + 32'd1;
                    beat_n  = beat_q - BURST_W'(1);
                    gap_n   = BURST_W'(1);
                    state_n = ST_RD_BURST;
                end else begin
                    lat_n = lat_q - LAT_W'(1);
                end
            end
            ST_RD_BURST: begin
                if (beat_q == '0) begin
                    state_n = ST_IDLE;
                end else if (bubble) begin
                    gap_n = '0;
                end else begin
                    issue  = 1'b1;
                    idx_n  = idx_q + 32'd1;
                    beat_n = beat_q - BURST_W'(1);
                    gap_n  = gap_q + BURST_W'(1);
                end
            end
            ST_WR_BURST: begin
                proto_set = read;
                if (bubble) begin
                    gap_n = '0;
                end else if (write) begin
                    commit = 1'b1;
                    idx_n  = idx_q + 32'd1;
                    beat_n = beat_q - BURST_W'(1);
                    gap_n  = gap_q + BURST_W'(1);
                    if (beat_q == BURST_W'(1)) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        wait_n = (state_n == ST_RD_LAT) || (state_n == ST_RD_BURST) ||
                 ((state_n == ST_WR_BURST) && (GAP_EVERY != 0) &&
                  (gap_n == BURST_W'(GAP_EVERY)));
    end

    avmm_resp_ram #(
        .DATA_W (SDRAM_W),
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (commit && !cur_oob),
        .re    (issue && !cur_oob),
        .addr  (cur_idx[AW-1:0]),
        .wdata (writedata),
        .be    (byteenable),
        .q     (ram_q)
    );

    // State, counters, read-return pipeline and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            gap_q         <= '0;
            lat_q         <= '0;
            idx_q         <= '0;
            below_q       <= 1'b0;
            pend_q        <= 1'b0;
            pend_oob_q    <= 1'b0;
            waitrequest   <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            busy          <= 1'b0;
            err_oob       <= 1'b0;
            err_proto     <= 1'b0;
        end else begin
            state_q       <= state_n;
            beat_q        <= beat_n;
            gap_q         <= gap_n;
            lat_q         <= lat_n;
            idx_q         <= idx_n;
            below_q       <= below_n;
            pend_q        <= issue;
            pend_oob_q    <= cur_oob;
            waitrequest   <= wait_n;
            readdatavalid <= pend_q;
            busy          <= (state_n != ST_IDLE);
            if (pend_q) begin
                readdata <= pend_oob_q ? '0 : ram_q;
            end
            if ((issue || commit) && cur_oob) begin
                err_oob <= 1'b1;
            end
            if (proto_set) begin
                err_proto <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avmm_burst_responder.sv
// Directed bench: two responders (no bubbles / GAP_EVERY=2) behind a shared stimulus mux.
module tb_avmm_burst_responder;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address;
    logic [10:0]  burstcount;
    logic         read, write;
    logic [127:0] writedata;
    logic [15:0]  byteenable;
    bit           sel;

    logic         wr0, rdv0, busy0, eo0, ep0;
    logic         wr1, rdv1, busy1, eo1, ep1;
    logic [127:0] rd0, rd1;

    logic         wreq, rdv, bsy, eoob, eprot;
    logic [127:0] rdata;

    assign wreq  = sel ? wr1   : wr0;
    assign rdv   = sel ? rdv1  : rdv0;
    assign bsy   = sel ? busy1 : busy0;
    assign eoob  = sel ? eo1   : eo0;
    assign eprot = sel ? ep1   : ep0;
    assign rdata = sel ? rd1   : rd0;

    always #5 clk = ~clk;

    avmm_burst_responder #(.GAP_EVERY(0)) dut0 (
        .clk(clk), .rst(rst), .address(address), .burstcount(burstcount),
        .read(read && !sel), .write(write && !sel), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(wr0), .readdata(rd0),
        .readdatavalid(rdv0), .busy(busy0), .err_oob(eo0), .err_proto(ep0)
    );

    avmm_burst_responder #(.GAP_EVERY(2)) dut1 (
        .clk(clk), .rst(rst), .address(address), .burstcount(burstcount),
        .read(read && sel), .write(write && sel), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(wr1), .readdata(rd1),
        .readdatavalid(rdv1), .busy(busy1), .err_oob(eo1), .err_proto(ep1)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] model [2][DEPTH];
    logic [127:0] wbuf [16];
    logic [127:0] rbuf [16];

    typedef struct {
        bit          g;
        logic [31:0] addr;
        int          n;
        int          lat;
        logic [15:0] patt;
        int          plen;
    } rd_vec_t;

    rd_vec_t vec [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pre(input int i);
        return {64'hCAFE_0000_0000_0000 + 64'(i), 64'(i)};
    endfunction

    // Write burst honouring waitrequest; optional single write=0 cycle before beat idle_at.
    task automatic write_burst(input logic [31:0] a, input int n, input logic [15:0] be,
                               input int idle_at);
        int  k = 0;
        int  cyc = 0;
        int  widx;
        bit  idled = 0;
        bit  stalled;
        address    = a;
        burstcount = 11'(n);
        byteenable = be;
        while (k < n && cyc < 200) begin
            if (k == idle_at && !idled) begin
                write = 1'b0;
                idled = 1;
            end else begin
                write     = 1'b1;
                writedata = wbuf[k];
            end
            stalled = wreq;
            tick();
            cyc++;
            if (write && !stalled) begin
                widx = int'((a - BASE) >> 4) + k;
                if (a >= BASE && widx < DEPTH) begin
                    for (int b = 0; b < 16; b++) begin
                        if (be[b]) model[int'(sel)][widx][8*b +: 8] = wbuf[k][8*b +: 8];
                    end
                end
                k++;
            end
        end
        write = 1'b0;
        check("wr_beats", 128'(k), 128'(n));
    endtask

    // Read burst: records beats, first-valid latency, valid pattern and waitrequest behaviour.
    task automatic read_burst(input logic [31:0] a, input int n, output int lat,
                              output logic [15:0] patt, output int plen,
                              output int wbad, output logic wlast);
        int got = 0;
        int cyc = 0;
        bit started = 0;
        lat = -1; patt = '0; plen = 0; wbad = 0; wlast = 1'bx;
        address    = a;
        burstcount = 11'(n);
        read       = 1'b1;
        tick();
        read = 1'b0;
        if (wreq !== 1'b1) wbad++;
        while (got < n && cyc < 64) begin
            tick();
            cyc++;
            if (rdv === 1'b1) begin
                if (!started) begin
                    started = 1;
                    lat = cyc;
                end
                rbuf[got] = rdata;
                got++;
                patt = {patt[14:0], 1'b1};
                plen++;
                if (got == n) wlast = wreq;
                else if (wreq !== 1'b1) wbad++;
            end else begin
                if (started) begin
                    patt = {patt[14:0], 1'b0};
                    plen++;
                end
                if (wreq !== 1'b1) wbad++;
            end
        end
        check("rd_beats", 128'(got), 128'(n));
    endtask

    initial begin
        int           lat, plen, wbad, idx, cnt;
        logic [15:0]  patt;
        logic         wlast;
        logic [127:0] exp;

        rst = 1'b1; read = 1'b0; write = 1'b0; sel = 0;
        address = '0; burstcount = '0; writedata = '0; byteenable = '0;
        tick(); tick(); tick();

        // Reset state of both responders.
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #0;
            check("rst_waitrequest", 128'(wreq), 128'(0));
            check("rst_rdv", 128'(rdv), 128'(0));
            check("rst_readdata", rdata, 128'(0));
            check("rst_busy", 128'(bsy), 128'(0));
            check("rst_err", {126'(0), eoob, eprot}, 128'(0));
        end
        rst = 1'b0;
        tick();

        // Preload words 0..15 and the last word in both RAMs.
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            for (int i = 0; i < 16; i++) wbuf[i] = pre(i);
            write_burst(BASE, 16, 16'hFFFF, -1);
            wbuf[0] = pre(DEPTH - 1);
            write_burst(BASE + 32'((DEPTH - 1) * 16), 1, 16'hFFFF, -1);
            tick();
        end

        vec[0] = '{0, BASE + 32'h40,     4, 2, 16'b1111,    4};
        vec[1] = '{1, BASE,              5, 2, 16'b1101101, 7};
        vec[2] = '{0, BASE + 32'h0A0,    1, 2, 16'b1,       1};
        vec[3] = '{1, BASE + 32'h030,    2, 2, 16'b11,      2};
        vec[4] = '{1, BASE + 32'h070,    3, 2, 16'b1101,    4};

        for (int v = 0; v < 5; v++) begin
            sel = vec[v].g;
            read_burst(vec[v].addr, vec[v].n, lat, patt, plen, wbad, wlast);
            check($sformatf("v%0d_latency", v), 128'(lat), 128'(vec[v].lat));
            check($sformatf("v%0d_pattern", v), 128'(patt), 128'(vec[v].patt));
            check($sformatf("v%0d_patlen", v), 128'(plen), 128'(vec[v].plen));
            check($sformatf("v%0d_wait_high", v), 128'(wbad), 128'(0));
            check($sformatf("v%0d_wait_last", v), 128'(wlast), 128'(0));
            idx = int'((vec[v].addr - BASE) >> 4);
            for (int k = 0; k < vec[v].n; k++) begin
                check($sformatf("v%0d_data%0d", v, k), rbuf[k], model[int'(sel)][idx + k]);
            end
            tick();
            check($sformatf("v%0d_rdv_after", v), 128'(rdv), 128'(0));
            check($sformatf("v%0d_busy_after", v), 128'(bsy), 128'(0));
        end

        // Byte-masked write burst with a master throttle cycle, then read back.
        sel = 0;
        for (int i = 0; i < 3; i++) wbuf[i] = {64'h1111_2222_3333_4444, 64'hA0A0_0000_0000_0000 + 64'(i)};
        write_burst(BASE, 3, 16'h00FF, 2);
        tick();
        read_burst(BASE, 3, lat, patt, plen, wbad, wlast);
        for (int k = 0; k < 3; k++) begin
            exp = {pre(k)[127:64], 64'hA0A0_0000_0000_0000 + 64'(k)};
            check($sformatf("be_data%0d", k), rbuf[k], exp);
        end
        tick();

        // Burst straddling the end of the RAM.
        check("oob_before", 128'(eoob), 128'(0));
        read_burst(BASE + 32'((DEPTH - 1) * 16), 2, lat, patt, plen, wbad, wlast);
        check("oob_beat0", rbuf[0], pre(DEPTH - 1));
        check("oob_beat1", rbuf[1], 128'(0));
        check("oob_flag", 128'(eoob), 128'(1));
        tick();

        // Reset in the second RD_BURST cycle of an 8-beat read.
        address = BASE + 32'h40; burstcount = 11'd8; read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        tick();
        check("rst_mid_beat0_valid", 128'(rdv), 128'(1));
        check("rst_mid_beat0_data", rdata, pre(4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rdv", 128'(rdv), 128'(0));
        check("rst_mid_wait", 128'(wreq), 128'(0));
        check("rst_mid_busy", 128'(bsy), 128'(0));
        check("rst_mid_err_oob", 128'(eoob), 128'(0));
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rdv === 1'b1) cnt++;
        end
        check("rst_mid_no_beats", 128'(cnt), 128'(0));
        read_burst(BASE + 32'h60, 2, lat, patt, plen, wbad, wlast);
        check("rst_after_data0", rbuf[0], pre(6));
        check("rst_after_data1", rbuf[1], pre(7));
        check("rst_after_latency", 128'(lat), 128'(2));
        tick();

        // read and write together in IDLE: write wins.
        check("proto_before", 128'(eprot), 128'(0));
        address = BASE + 32'h140; burstcount = 11'd1;
        writedata = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
        byteenable = 16'hFFFF; read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (rdv === 1'b1) cnt++;
            tick();
        end
        check("proto_no_beats", 128'(cnt), 128'(0));
        check("proto_flag", 128'(eprot), 128'(1));
        read_burst(BASE + 32'h140, 1, lat, patt, plen, wbad, wlast);
        check("proto_write_data", rbuf[0], 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
